apb_vgatext_master: RTL
=======================

Name: apb_vgatext_master

Overview:
APB requester that drives the VGA character-generator APB slave from a byte-wide character stream.
- Keeps a text cursor (column/row) and turns each accepted printable character into one APB write to BASE_ADDR + row*COLS + col.
- Handles newline locally, runs a full-screen clear sequence on request, and flags slave errors and timeouts.
- Sits between a CPU-side or UART-side character source and the vgachargen APB slave.

Parameters:
APB_ADDR_WIDTH, 13, width of apb_paddr_o
APB_DATA_WIDTH, 32, width of apb_pwdata_o / apb_prdata_i
BASE_ADDR, 0, APB address of screen cell (0,0)
COLS, 80, characters per row
ROWS, 30, rows per screen
TIMEOUT, 16, max ACCESS cycles waiting for apb_pready_i before abort

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
char_valid_i  in  1  character available
char_i  in  8  character code
char_ready_o  out  1  character accepted when valid&ready
clear_i  in  1  pulse: request full-screen clear
err_clr_i  in  1  pulse: clear err_o
busy_o  out  1  transfer, clear, or pending clear in progress
err_o  out  1  sticky: slave error or timeout seen
cursor_col_o  out  $clog2(COLS)  current column
cursor_row_o  out  $clog2(ROWS)  current row
apb_paddr_o  out  APB_ADDR_WIDTH  APB address
apb_pwdata_o  out  APB_DATA_WIDTH  {zeros, char[7:0]}
apb_pwrite_o  out  1  always 1 during a transfer, 0 otherwise
apb_psel_o  out  1  APB select
apb_penable_o  out  1  APB enable
apb_prdata_i  in  APB_DATA_WIDTH  unused; ignored
apb_pready_i  in  1  slave ready
apb_pslverr_i  in  1  slave error, sampled with pready

Behaviour:
- Reset (async, rst_i=1):
  - state IDLE; cursor (0,0); err_o=0; clear pending=0.
  - psel, penable, pwrite, paddr, pwdata = 0.
  - busy_o=0; char_ready_o=1 after reset release.
  - Asserting reset mid-transfer drops psel/penable immediately; the write is abandoned.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - char_ready_o = 1 iff no clear is active or pending.
  - If clear_i=1, clear takes priority over char_valid_i in the same cycle (char_ready_o=0).
  - Accepted char 0x0A (newline): no APB transfer. Cursor becomes col 0, row+1; row ROWS-1 wraps to 0. Next char is accepted the following cycle.
  - Any other accepted char: latch char and address, go to SETUP.
- SETUP, 1 cycle: psel=1, penable=0, pwrite=1; paddr and pwdata stable. Then ACCESS.
- ACCESS: psel=1, penable=1; paddr and pwdata held.
  - On pready=1:
    - pslverr=1 sets err_o.
    - Cursor advances: col+1; col COLS-1 goes to col 0, row+1; row ROWS-1 wraps to row 0.
    - Go to IDLE, or to SETUP for the next cell when clearing.
  - Timeout counter counts ACCESS cycles and resets on entry to SETUP. After TIMEOUT cycles without pready: deassert psel/penable, set err_o, advance cursor, leave ACCESS as on completion.
- Write throughput: one char per 3 cycles minimum (IDLE, SETUP, ACCESS with zero-wait slave).
- Clear sequence:
  - Writes 0x20 to linear indices 0..COLS*ROWS-1 in ascending order.
  - ACCESS goes straight to SETUP between cells; no IDLE gap.
  - On the final completion: cursor = (0,0), return to IDLE.
  - Errors and timeouts set err_o; the sequence continues.
- clear_i outside IDLE, or during a clear: recorded as pending. Serviced on return to IDLE. A request during a clear restarts the clear after it ends; multiple pulses collapse into one.
- busy_o = (state != IDLE) | clear active | clear pending.
- err_o: set has priority over err_clr_i in the same cycle.
- Address arithmetic: row*COLS + col is computed at full width, then added to BASE_ADDR and truncated to APB_ADDR_WIDTH. COLS*ROWS + BASE_ADDR must fit; elaboration asserts this.

Decomposition:
- Package vgatext_pkg:
  - state enum (IDLE/SETUP/ACCESS)
  - CHAR_NEWLINE = 8'h0A
  - CHAR_SPACE = 8'h20
  - default COLS/ROWS/TIMEOUT constants
- Sub-module vgatext_cursor:
  - col/row counters with advance, newline, and reset-to-origin inputs; wrap logic.
  - Outputs the linear cell index.

Test Plan:
1. Zero-wait slave, send 'A'(0x41) after reset -> SETUP with paddr=0, pwdata=0x41, psel=1, penable=0; next cycle penable=1; then cursor (1,0); char_ready_o=1 again 3 cycles after acceptance.
2. Send 81 chars 0x30.. -> 80th write at paddr=79, cursor (0,1); 81st at paddr=80; at (79,29) the next write wraps the cursor to (0,0).
3. Cursor (5,2), send 0x0A -> no psel; cursor (0,3) next cycle. At row 29, 0x0A -> row 0.
4. Slave returns pslverr=1 with pready on a write at (3,0) -> err_o=1 held; cursor (4,0); err_clr_i pulse -> err_o=0.
5. Slave never asserts pready, TIMEOUT=16 -> psel drops after 16 ACCESS cycles, err_o=1, state IDLE, char_ready_o=1.
6. clear_i pulse while a char write is in flight -> the write completes, then 2400 writes of pwdata=0x20 at paddr 0..2399. busy_o=1 throughout, char_ready_o=0, cursor ends (0,0). Reset asserted mid-clear -> psel=0 immediately, busy_o=0.

Source files
------------

// File: rtl/vgatext_pkg.sv
// vgatext_pkg: shared state encoding, character codes and default geometry for the VGA text APB master
package vgatext_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    localparam logic [7:0] CHAR_NEWLINE = 8'h0A;
    localparam logic [7:0] CHAR_SPACE   = 8'h20;
    localparam int DEF_COLS    = 80;
    localparam int DEF_ROWS    = 30;
    localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/vgatext_cursor.sv
// vgatext_cursor: column/row text cursor with wrap, newline and origin reset; exposes the linear cell index
//   clk_i, rst_i : clock, asynchronous active-high reset
//   advance_i    : step one cell right, wrapping to next row and back to the top
//   newline_i    : jump to column 0 of the next row (wrapping)
//   origin_i     : return to (0,0); highest priority
//   col_o, row_o : current position
//   idx_o        : row*COLS + col
module vgatext_cursor #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           advance_i,
    input  logic                           newline_i,
    input  logic                           origin_i,
    output logic [$clog2(COLS)-1:0]        col_o,
    output logic [$clog2(ROWS)-1:0]        row_o,
    output logic [$clog2(COLS*ROWS)-1:0]   idx_o
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int IW = $clog2(COLS*ROWS);
    logic [RW-1:0] row_next;
    logic          col_last;
    assign row_next = (row_o == RW'(ROWS-1)) ? '0 : row_o + RW'(1);
    assign col_last = col_o == CW'(COLS-1);
    assign idx_o    = IW'(row_o) * IW'(COLS) + IW'(col_o);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_o <= '0;
            row_o <= '0;
        end else if (origin_i) begin
            col_o <= '0;
            row_o <= '0;
        end else if (newline_i || (advance_i && col_last)) begin
            col_o <= '0;
            row_o <= row_next;
        end else if (advance_i) begin
            col_o <= col_o + CW'(1);
        end
    end
endmodule

// File: rtl/apb_vgatext_master.sv
// apb_vgatext_master: APB requester turning a character stream into VGA text-cell writes
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   char_valid_i/char_i   : character stream in; char_ready_o accepts it
//   clear_i, err_clr_i    : full-screen clear request, sticky error clear
//   busy_o, err_o         : activity flag, sticky slave-error/timeout flag
//   cursor_col_o/row_o    : text cursor
//   apb_*                 : APB requester interface (write-only; prdata ignored)
module apb_vgatext_master
    import vgatext_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 13,
    parameter int APB_DATA_WIDTH = 32,
    parameter int BASE_ADDR      = 0,
    parameter int COLS           = DEF_COLS,
    parameter int ROWS           = DEF_ROWS,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       char_valid_i,
    input  logic [7:0]                 char_i,
    output logic                       char_ready_o,
    input  logic                       clear_i,
    input  logic                       err_clr_i,
    output logic                       busy_o,
    output logic                       err_o,
    output logic [$clog2(COLS)-1:0]    cursor_col_o,
    output logic [$clog2(ROWS)-1:0]    cursor_row_o,
    output logic [APB_ADDR_WIDTH-1:0]  apb_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]  apb_pwdata_o,
    output logic                       apb_pwrite_o,
    output logic                       apb_psel_o,
    output logic                       apb_penable_o,
    input  logic [APB_DATA_WIDTH-1:0]  apb_prdata_i,
    input  logic                       apb_pready_i,
    input  logic                       apb_pslverr_i
);
    localparam int IW = $clog2(COLS*ROWS);
    localparam int TW = $clog2(TIMEOUT+1);
    if (BASE_ADDR + COLS*ROWS > (1 << APB_ADDR_WIDTH)) begin : g_fit
        $error("apb_vgatext_master: screen does not fit in the APB address space");
    end
    state_t        state;
    logic [TW-1:0] tcnt;
    logic [IW-1:0] idx;
    logic          clear_active, clear_pend;
    logic          start_clr, accept, is_nl, tmo, done, last, err_set;
    logic          unused_prdata;
    assign unused_prdata = ^apb_prdata_i;
    // a fresh clear_i pulse in IDLE starts immediately, same as a pending one
    assign start_clr    = clear_i | clear_pend;
    assign char_ready_o = state == IDLE && !clear_active && !start_clr;
    assign accept       = char_valid_i & char_ready_o;
    assign is_nl        = char_i == CHAR_NEWLINE;
    assign tmo          = tcnt == TW'(TIMEOUT-1);
    assign done         = state == ACCESS && (apb_pready_i || tmo);
    assign last         = idx == IW'(COLS*ROWS-1);
    assign err_set      = done && (apb_pready_i ? apb_pslverr_i : 1'b1);
    assign busy_o       = state != IDLE || clear_active || clear_pend;
    // the cursor doubles as the clear index: reset to origin at clear start,
    // advanced per cell, and it wraps back to (0,0) on the final cell
    vgatext_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance_i (done),
        .newline_i (accept && is_nl),
        .origin_i  (state == IDLE && start_clr),
        .col_o     (cursor_col_o),
        .row_o     (cursor_row_o),
        .idx_o     (idx)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            tcnt          <= '0;
            clear_active  <= 1'b0;
            clear_pend    <= 1'b0;
            err_o         <= 1'b0;
            apb_paddr_o   <= '0;
            apb_pwdata_o  <= '0;
            apb_pwrite_o  <= 1'b0;
            apb_psel_o    <= 1'b0;
            apb_penable_o <= 1'b0;
        end else begin
            err_o <= err_set | (err_o & ~err_clr_i);
            if (clear_i && (state != IDLE || clear_active))
                clear_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_clr) begin
                        clear_active <= 1'b1;
                        clear_pend   <= 1'b0;
                        apb_paddr_o  <= APB_ADDR_WIDTH'(BASE_ADDR);
                        apb_pwdata_o <= APB_DATA_WIDTH'(CHAR_SPACE);
                        apb_psel_o   <= 1'b1;
                        apb_pwrite_o <= 1'b1;
                        state        <= SETUP;
                    end else if (accept && !is_nl) begin
                        apb_paddr_o  <= APB_ADDR_WIDTH'(BASE_ADDR + int'(idx));
                        apb_pwdata_o <= APB_DATA_WIDTH'(char_i);
                        apb_psel_o   <= 1'b1;
                        apb_pwrite_o <= 1'b1;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    apb_penable_o <= 1'b1;
                    tcnt          <= '0;
                    state         <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        apb_penable_o <= 1'b0;
                        if (clear_active && !last) begin
                            apb_paddr_o <= apb_paddr_o + APB_ADDR_WIDTH'(1);
                            state       <= SETUP;
                        end else begin
                            apb_psel_o   <= 1'b0;
                            apb_pwrite_o <= 1'b0;
                            clear_active <= 1'b0;
                            state        <= IDLE;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
